// File: rtl/phase_seq_ctrl_pkg.sv
// phase_pkg: shared state encoding and abort data constant for phase_seq_ctrl
package phase_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE} phase_state_t;
  localparam bit RDATA_ABORT = 1'b0;
endpackage

// File: rtl/phase_seq_ctrl_if.sv
// phase_seq_ctrl_if: data-memory handshake (master = controller, slave = memory); mem_req, mem_ack, rdata_in
interface phase_seq_ctrl_if #(parameter int WIDTH = 32);
  logic mem_req;
  logic mem_ack;
  logic [WIDTH-1:0] rdata_in;
  modport master(output mem_req, input mem_ack, rdata_in);
  modport slave(input mem_req, output mem_ack, rdata_in);
endinterface

// File: rtl/phase_seq_ctrl_cnt.sv
// phase_cnt: enabled wrapping counter with async active-low clear; ports clk, reset_n, en, q
module phase_cnt #(parameter int W = 32) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (en) q <= q + 1'b1;
endmodule

// File: rtl/phase_seq_ctrl.sv
// phase_seq_ctrl: phase ring to stage enables, memory handshake with timeout, phase check, debug counters; ports clk, reset_n, ph0-2, mem_op, mem (handshake), rdata, enables, stall, errors, counters
module phase_seq_ctrl
  import phase_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ph0,
  input  logic                 ph1,
  input  logic                 ph2,
  input  logic                 mem_op,
  phase_seq_ctrl_if.master     mem,
  output logic [WIDTH-1:0]     rdata,
  output logic                 fetch_en,
  output logic                 exec_en,
  output logic                 wb_en,
  output logic                 stall,
  output logic                 mem_err,
  output logic                 phase_err,
  output logic [CNT_W-1:0]     retired_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  phase_state_t state, state_nx;
  logic [TW-1:0] tcnt;
  logic legal, in_req, ack, tmo;
  assign legal  = $onehot({ph0, ph1, ph2});
  assign in_req = state == REQ;
  assign ack    = in_req & mem.mem_ack;
  // tcnt holds REQ cycles already elapsed, so this is the TIMEOUT-th ack-less cycle
  assign tmo    = in_req & ~mem.mem_ack & (tcnt == TW'(TIMEOUT - 1));
  always_comb begin
    state_nx = !legal ? state :
               state == IDLE ? ((ph1 && mem_op) ? REQ : IDLE) :
               state == REQ  ? (ack ? (ph2 ? IDLE : DONE) : (tmo ? DONE : REQ)) :
               (ph2 ? IDLE : DONE);
    mem.mem_req = in_req;
    stall       = state != IDLE;
    fetch_en    = reset_n & ph0 & (state == IDLE);
    exec_en     = reset_n & ph1 & (state == IDLE);
    wb_en       = reset_n & ph2 & ((state == IDLE) | (state == DONE) | ack);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tcnt <= '0;
    else if (legal) tcnt <= (state == IDLE) ? '0 : tcnt + TW'(in_req);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rdata <= '0;
    else if (legal && ack) rdata <= mem.rdata_in;
    else if (legal && tmo) rdata <= {WIDTH{RDATA_ABORT}};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) mem_err <= 1'b0;
    else if (legal && tmo) mem_err <= 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) phase_err <= 1'b0;
    else if (!legal) phase_err <= 1'b1;
  phase_cnt #(.W(CNT_W)) u_ret (.clk(clk), .reset_n(reset_n), .en(wb_en), .q(retired_cnt));
  phase_cnt #(.W(CNT_W)) u_stl (.clk(clk), .reset_n(reset_n), .en(stall), .q(stall_cnt));
endmodule
